// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and median-index helper for the sort-RAM reader.
package sort_pkg;

  localparam int SORT_DATA_W = 24;
  localparam int SORT_ADDR_W = 10;
  localparam int SORT_DEPTH  = 540;

  localparam logic [SORT_ADDR_W-1:0] SORT_DEPTH_A = SORT_ADDR_W'(SORT_DEPTH);
  localparam logic [SORT_ADDR_W-1:0] SORT_ONE_A   = SORT_ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    ZERO
  } sort_state_e;

  // Lower median index (count-1)>>1; only meaningful for count >= 1.
  function automatic logic [SORT_ADDR_W-1:0] sort_median_idx(input logic [SORT_ADDR_W-1:0] cnt);
    logic [SORT_ADDR_W-1:0] last_idx;
    last_idx = cnt - SORT_ONE_A;
    return last_idx >> 1;
  endfunction

endpackage

// File: rtl/sort_out_fifo.sv
// Two-entry synchronous FIFO; entry 0 is always the head, so the output is
// a plain register and stays stable until a pop.
module sort_out_fifo #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic [1:0]   r_occ;

  // NOTE: both entries are reset because the head register drives a
  // top-level output whose reset value must be zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_mem0 <= i_din;
          else               r_mem1 <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_din;
          end else begin
            r_mem0 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout = r_mem0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/spram_sort_reader.sv
// Sweeps the sort RAM 0..count-1 onto a valid/ready stream, hiding the RAM's
// registered read latency, and captures the lower median of the frame.
module spram_sort_reader
  import sort_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SORT_ADDR_W-1:0] count,
  output logic [SORT_ADDR_W-1:0] ram_addr,
  input  logic [SORT_DATA_W-1:0] ram_q,
  output logic                   busy,
  output logic [SORT_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [SORT_DATA_W-1:0] median,
  output logic                   median_valid,
  output logic                   done
);

  localparam int DATA_W = SORT_DATA_W;
  localparam int ADDR_W = SORT_ADDR_W;

  sort_state_e       r_state;
  sort_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_med_idx;
  logic [ADDR_W-1:0] r_q_idx;
  logic              r_inflight;
  logic              r_q_v;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_median;
  logic              r_median_valid;

  logic [ADDR_W-1:0] w_count_clamped;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_accept;
  logic              w_issue;
  logic              w_finish;
  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_drained;
  logic [2:0]        w_load;
  logic [1:0]        w_occ;
  logic [DATA_W:0]   w_fifo_dout;

  assign w_count_clamped = (count > SORT_DEPTH_A) ? SORT_DEPTH_A : count;

  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid & out_ready;

  // r_inflight: ram_addr changed at the last edge. r_q_v: ram_q holds an
  // uncaptured word; holding ram_addr keeps the RAM re-reading it.
  assign w_load    = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_credit  = w_load < (3'd2 + {2'b00, w_pop});
  assign w_push    = r_q_v & ((w_occ != 2'd2) | w_pop);
  assign w_drained = ~r_inflight & ~r_q_v & ((w_occ == 2'd0) | ((w_occ == 2'd1) & w_pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_issue_addr = ram_addr + SORT_ONE_A;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_issue_addr = '0;
          if (w_count_clamped == '0) begin
            w_state_nxt = ZERO;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = (w_count_clamped == SORT_ONE_A) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_issue_addr == r_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drained) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ZERO: begin
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr       <= '0;
      r_last         <= '0;
      r_med_idx      <= '0;
      r_q_idx        <= '0;
      r_inflight     <= 1'b0;
      r_q_v          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_median       <= '0;
      r_median_valid <= 1'b0;
    end else begin
      r_done     <= w_finish;
      r_inflight <= w_issue;
      r_q_v      <= r_inflight | (r_q_v & ~w_push);
      if (w_issue)    ram_addr <= w_issue_addr;
      if (r_inflight) r_q_idx  <= ram_addr;
      if (w_accept) begin
        r_busy         <= 1'b1;
        r_median_valid <= 1'b0;
        r_last         <= w_count_clamped - SORT_ONE_A;
        r_med_idx      <= sort_median_idx(w_count_clamped);
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      if (w_push && (r_q_idx == r_med_idx)) begin
        r_median       <= ram_q;
        r_median_valid <= 1'b1;
      end
    end
  end

  sort_out_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .i_push(w_push),
    .i_din ({(r_q_idx == r_last), ram_q}),
    .i_pop (w_pop),
    .o_dout(w_fifo_dout),
    .o_occ (w_occ)
  );

  assign out_data     = w_fifo_dout[DATA_W-1:0];
  assign out_last     = out_valid & w_fifo_dout[DATA_W];
  assign busy         = r_busy;
  assign done         = r_done;
  assign median       = r_median;
  assign median_valid = r_median_valid;

endmodule
